// File: rtl/fwft_axis_reader_pkg.sv
// Shared definitions for the FWFT-to-AXI4-Stream reader: entry field layout and counter width.
package fwft_axis_reader_pkg;

  localparam int PKT_CNT_W = 32;

  typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

  // Entry layout is {TLAST, TKEEP, TDATA}, TDATA in the low bits.
  function automatic int keep_width(input int dw);
    return dw / 8;
  endfunction

  function automatic int keep_lsb(input int dw);
    return dw;
  endfunction

  function automatic int tlast_bit(input int dw);
    return dw + dw / 8;
  endfunction

endpackage

// File: rtl/fwft_axis_reader_if.sv
// AXI4-Stream bus bundle; master drives data/valid, slave drives ready.
interface fwft_axis_reader_if #(
  parameter int DATA_WIDTH = 64
) ();
  import fwft_axis_reader_pkg::*;

  localparam int KEEP_WIDTH = keep_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] TDATA;
  logic [KEEP_WIDTH-1:0] TKEEP;
  logic                  TLAST;
  logic                  TVALID;
  logic                  TREADY;

  modport master (output TDATA, TKEEP, TLAST, TVALID, input TREADY);
  modport slave  (input TDATA, TKEEP, TLAST, TVALID, output TREADY);

endinterface

// File: rtl/fwft_axis_reader_skid.sv
// Two-entry register slice: a registered output stage plus one skid stage, each with a valid bit.
module fwft_axis_reader_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             skid_valid_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_free;

  assign out_free = !out_valid_q || out_ready_i;

  // The producer must not offer a beat while the skid is full and the output is stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) skid_data_d = in_data_i;
      end else if (in_valid_i) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/fwft_axis_reader.sv
// Pops {TLAST,TKEEP,TDATA} entries from a first-word-fall-through FIFO and presents them
// as a registered AXI4-Stream master, with a packet counter and an in-packet flag.
module fwft_axis_reader
  import fwft_axis_reader_pkg::*;
#(
  parameter int  DATA_WIDTH = 64,
  localparam int KEEP_WIDTH = keep_width(DATA_WIDTH),
  localparam int FIFO_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [FIFO_WIDTH-1:0] FIFO_DO,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RDEN,
  fwft_axis_reader_if.master    m_axis,
  output logic [PKT_CNT_W-1:0]  PKT_CNT,
  output logic                  IN_PKT
);

  localparam int TLAST_BIT = tlast_bit(DATA_WIDTH);
  localparam int KEEP_LSB  = keep_lsb(DATA_WIDTH);

  logic                  skid_valid;
  logic                  out_valid;
  logic [FIFO_WIDTH-1:0] out_entry;
  logic                  xfer;
  pkt_cnt_t              pkt_cnt_q, pkt_cnt_d;
  logic                  in_pkt_q, in_pkt_d;

  // Pop only depends on registered skid state, so TREADY never reaches FIFO_RDEN.
  assign FIFO_RDEN = !FIFO_EMPTY && !skid_valid && !RST;

  fwft_axis_reader_skid #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk_i        (CLK),
    .rst_i        (RST),
    .in_valid_i   (FIFO_RDEN),
    .in_data_i    (FIFO_DO),
    .out_ready_i  (m_axis.TREADY),
    .out_valid_o  (out_valid),
    .out_data_o   (out_entry),
    .skid_valid_o (skid_valid)
  );

  assign m_axis.TVALID = out_valid;
  assign m_axis.TDATA  = out_entry[DATA_WIDTH-1:0];
  assign m_axis.TKEEP  = out_entry[TLAST_BIT-1:KEEP_LSB];
  assign m_axis.TLAST  = out_entry[TLAST_BIT];

  assign xfer = out_valid && m_axis.TREADY;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    in_pkt_d  = in_pkt_q;
    if (xfer) begin
      if (out_entry[TLAST_BIT]) begin
        pkt_cnt_d = pkt_cnt_q + pkt_cnt_t'(1);
        in_pkt_d  = 1'b0;
      end else begin
        in_pkt_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pkt_cnt_q <= '0;
      in_pkt_q  <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      in_pkt_q  <= in_pkt_d;
    end
  end

  assign PKT_CNT = pkt_cnt_q;
  assign IN_PKT  = in_pkt_q;

endmodule
